seven_seg_readback: RTL

- Receive side of the multiplexed four-digit seven-segment interface driven by the stopwatch display controller.
- Samples the `anode`/`segments` pins, waits for each digit dwell to settle, and decodes segment patterns back to BCD digits.
- Reassembles complete MM:SS frames and reports value, errors and staleness.
- Used for on-board self-check and as the scoreboard front end in stopwatch benches.

---
 rtl/seven_seg_readback.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_readback.sv
// Receive side of a multiplexed four-digit seven-segment display.
// Samples anode/segment pins, waits for each digit dwell to settle, decodes
// glyphs back to BCD and reassembles MM:SS frames with error and stale flags.
module seven_seg_readback #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TOTAL_W        = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         anode,
    input  logic [6:0]         segments,
    output logic [3:0]         min_tens,
    output logic [3:0]         min_units,
    output logic [3:0]         sec_tens,
    output logic [3:0]         sec_units,
    output logic [TOTAL_W-1:0] total_seconds,
    output logic               frame_valid,
    output logic               frame_ok,
    output logic               seg_error,
    output logic               anode_error,
    output logic               stale
);

    localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYCLES);
    localparam logic [ToW-1:0]   ToMax   = ToW'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {StCollect, StAssemble} state_e;

    // Active-low {g..a} glyph to BCD; all-off is blank (F), anything else E.
    function automatic logic [3:0] seg_decode(input logic [6:0] pat);
        logic [3:0] d;
        case (pat)
            7'h40:   d = 4'd0;
            7'h79:   d = 4'd1;
            7'h24:   d = 4'd2;
            7'h30:   d = 4'd3;
            7'h19:   d = 4'd4;
            7'h12:   d = 4'd5;
            7'h02:   d = 4'd6;
            7'h78:   d = 4'd7;
            7'h00:   d = 4'd8;
            7'h10:   d = 4'd9;
            7'h7F:   d = 4'hF;
            default: d = 4'hE;
        endcase
        return d;
    endfunction

    state_e               state_q, state_d;
    logic [10:0]          sample_q, sample_d;
    logic [StabW-1:0]     stab_q, stab_d;
    logic [ToW-1:0]       to_q, to_d;
    logic [3:0]           seen_q, seen_d;
    logic [3:0][3:0]      dig_q, dig_d;
    logic [3:0][3:0]      out_dig_q, out_dig_d;
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic                 fv_q, fv_d;
    logic                 ok_q, ok_d;
    logic                 seg_err_q, seg_err_d;
    logic                 an_err_q, an_err_d;
    logic                 stale_q, stale_d;

    logic                 capture_evt, capture, multi_low, slot_hit, timeout_hit;
    logic [1:0]           slot_idx;
    logic [3:0]           digit, mt_eff;
    logic                 frame_ok_c;
    logic [TOTAL_W-1:0]   total_c;

    // Stability tracking, anode decode and capture qualification.
    always_comb begin
        sample_d    = {anode, segments};
        stab_d      = StabW'(1);
        if (sample_d == sample_q) begin
            stab_d = (stab_q == StabMax) ? stab_q : stab_q + 1'b1;
        end
        // Fires once per dwell: only on the transition into saturation.
        capture_evt = (stab_d == StabMax) && (stab_q != StabMax);
        slot_hit    = 1'b0;
        multi_low   = 1'b0;
        slot_idx    = 2'd0;
        case (sample_q[10:7])
            4'b1110: begin slot_hit = 1'b1; slot_idx = 2'd0; end
            4'b1101: begin slot_hit = 1'b1; slot_idx = 2'd1; end
            4'b1011: begin slot_hit = 1'b1; slot_idx = 2'd2; end
            4'b0111: begin slot_hit = 1'b1; slot_idx = 2'd3; end
            4'b1111: ;
            default: multi_low = 1'b1;
        endcase
        capture     = capture_evt && slot_hit;
        digit       = seg_decode(sample_q[6:0]);
        timeout_hit = !capture && (to_q == ToMax - 1'b1);
    end

    // Frame qualification and MM:SS to seconds; blank minutes-tens reads as 0.
    always_comb begin
        mt_eff     = (dig_q[3] == 4'hF) ? 4'd0 : dig_q[3];
        frame_ok_c = ((dig_q[3] <= 4'd9) || (dig_q[3] == 4'hF)) && (dig_q[2] <= 4'd9) &&
                     (dig_q[1] <= 4'd5) && (dig_q[0] <= 4'd9);
        total_c    = '0;
        if (frame_ok_c) begin
            total_c = TOTAL_W'((32'(mt_eff) * 10 + 32'(dig_q[2])) * 60 +
                               32'(dig_q[1]) * 10 + 32'(dig_q[0]));
        end
    end

    // Next-state for timeout, seen-mask, frame FSM and registered outputs.
    always_comb begin
        to_d      = to_q;
        if (capture) begin
            to_d = '0;
        end else if (to_q != ToMax) begin
            to_d = to_q + 1'b1;
        end
        dig_d     = dig_q;
        if (capture) begin
            dig_d[slot_idx] = digit;
        end
        state_d   = state_q;
        seen_d    = seen_q;
        out_dig_d = out_dig_q;
        total_d   = total_q;
        ok_d      = ok_q;
        fv_d      = 1'b0;
        seg_err_d = capture && (digit == 4'hE);
        an_err_d  = capture_evt && multi_low;
        stale_d   = stale_q || timeout_hit;
        case (state_q)
            StCollect: begin
                if (capture) begin
                    seen_d = seen_q | ~sample_q[10:7];
                end else if (timeout_hit) begin
                    seen_d = '0;
                end
                if (seen_d == 4'hF) begin
                    state_d = StAssemble;
                end
            end
            StAssemble: begin
                fv_d      = 1'b1;
                out_dig_d = dig_q;
                ok_d      = frame_ok_c;
                total_d   = total_c;
                stale_d   = 1'b0;
                seen_d    = capture ? ~sample_q[10:7] : 4'h0;
                state_d   = StCollect;
            end
            default: state_d = StCollect;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StCollect;
            sample_q  <= '0;
            stab_q    <= '0;
            to_q      <= '0;
            seen_q    <= '0;
            dig_q     <= {4{4'hF}};
            out_dig_q <= {4{4'hF}};
            total_q   <= '0;
            fv_q      <= 1'b0;
            ok_q      <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            stab_q    <= stab_d;
            to_q      <= to_d;
            seen_q    <= seen_d;
            dig_q     <= dig_d;
            out_dig_q <= out_dig_d;
            total_q   <= total_d;
            fv_q      <= fv_d;
            ok_q      <= ok_d;
            seg_err_q <= seg_err_d;
            an_err_q  <= an_err_d;
            stale_q   <= stale_d;
        end
    end

    assign min_tens      = out_dig_q[3];
    assign min_units     = out_dig_q[2];
    assign sec_tens      = out_dig_q[1];
    assign sec_units     = out_dig_q[0];
    assign total_seconds = total_q;
    assign frame_valid   = fv_q;
    assign frame_ok      = ok_q;
    assign seg_error     = seg_err_q;
    assign anode_error   = an_err_q;
    assign stale         = stale_q;

endmodule
